wide_word_assembler: RTL
========================

// Module: wide_word_assembler
// PURPOSE
//  Deserialising gearbox: packs a stream of narrow beats into one WIDE_WIDTH word per completed group.
//  Sits directly upstream of the wide pass-through stages (65/128/256-bit) and drives their wide input.
//  Valid/ready on both sides. One-word output holding register, so accumulation of word N+1 overlaps
//  the drain of word N.
// PARAMETERS
//  WIDE_WIDTH    65   width of assembled output word, >= 1
//  NARROW_WIDTH  16   width of each input beat, 1..WIDE_WIDTH
//  BEATS         derived (localparam) = ceil(WIDE_WIDTH/NARROW_WIDTH); not overridable
//  LAST_BITS     derived (localparam) = WIDE_WIDTH - (BEATS-1)*NARROW_WIDTH, useful bits of final beat
// PORTS
//  clk        in   1             single clock, all state on rising edge
//  rst_n      in   1             asynchronous assert, active-low reset
//  clear      in   1             synchronous discard of partially assembled word
//  in_valid   in   1             beat offered
//  in_ready   out  1             beat accepted when in_valid && in_ready
//  in_data    in   NARROW_WIDTH  beat payload
//  out_valid  out  1             assembled word available
//  out_ready  in   1             consumer takes word when out_valid && out_ready
//  out_data   out  WIDE_WIDTH    assembled word
//  beat_idx   out  $clog2(BEATS+1)  index of next beat expected (0..BEATS-1), debug/visibility
// BEHAVIOUR
//  - Reset (rst_n=0, async): beat_idx=0, accumulator=0, out_valid=0, out_data=0. in_ready
//    evaluates to 1 once reset deasserts. A partial word or undelivered output is lost.
//  - Packing is LSB-first: beat k lands in bits [k*NARROW_WIDTH +: NARROW_WIDTH].
//  - Final beat (k=BEATS-1) contributes only in_data[LAST_BITS-1:0]; its upper bits are ignored.
//  - Beats 0..BEATS-2: in_ready=1 unconditionally. Accepting one writes the accumulator slice and
//    increments beat_idx.
//  - Final beat: in_ready = !out_valid || out_ready (combinational from out_ready). Accepting it
//    loads out_data = {final slice, accumulator}, sets out_valid, and wraps beat_idx to 0.
//  - Latency: out_valid rises on the edge that accepts the final beat; out_data is registered and
//    stable while out_valid=1 && out_ready=0.
//  - Output drain: out_valid && out_ready with no final beat accepted in the same cycle -> out_valid=0
//    next cycle. Drain and final-beat accept in the same cycle -> new word loaded, out_valid stays 1.
//    This gives no bubble, so the sustained rate is one word per BEATS cycles.
//  - clear=1: beat_idx=0 and accumulator=0 next edge; any beat offered that cycle is dropped, and
//    in_ready is forced to 0 while clear=1. clear does not affect out_valid/out_data; a held word is
//    still delivered.
//  - BEATS=1 (NARROW_WIDTH=WIDE_WIDTH): every beat is a final beat; the block degenerates to a
//    registered skid-free pipeline stage.
//  - No combinational path in_valid->out_valid. The only combinational path is out_ready->in_ready.
//  - Accumulator bits not yet written in the current word are don't-care, but they are zeroed on
//    reset and on clear for determinism.
// STRUCTURE
//  - wide_pkg: function ceil_div(int a, int b) and localparam helpers; BEATS/LAST_BITS derive from it.
//  - Single module. The accumulator is a WIDE_WIDTH-1-LAST_BITS+1 register; out_data is a separate
//    register.
//  - No sub-module required. Do not split out the output register.
// TESTING (WIDE_WIDTH=65, NARROW_WIDTH=16 unless stated)
//  1 Basic pack: beats 16'h1111,2222,3333,4444,0003 with out_ready=1 -> one cycle after 5th accept,
//    out_valid=1 and out_data=65'h1_4444_3333_2222_1111 (bit1 of last beat dropped).
//  2 Backpressure: out_ready=0, send word A (5 beats) then word B -> B beats 0..3 accepted, B beat 4
//    sees in_ready=0. Pulse out_ready -> A drains, B loads same edge, out_valid held 1.
//  3 Clear mid-word: 2 beats, clear=1 for 1 cycle, then 5 beats 16'hAAAA.. -> out_data built only from
//    post-clear beats, beat_idx=0 after clear.
//  4 Async reset mid-word: assert rst_n=0 between clock edges after 3 beats -> out_valid=0, beat_idx=0
//    immediately. Next full word packs correctly.
//  5 Throughput, WIDE_WIDTH=256, NARROW_WIDTH=64: 40 back-to-back beats, out_ready=1 -> 10 words,
//    out_valid high exactly every 4th cycle, data intact.
//  6 BEATS=1 (WIDE_WIDTH=NARROW_WIDTH=128): random in_valid/out_ready -> scoreboard: output sequence
//    equals input sequence, no loss or duplication.

Source files
------------

// File: rtl/wide_word_assembler_pkg.sv
// Shared sizing helpers for the narrow-to-wide gearbox. The beat count and the
// width of the final beat's useful slice both come from the two widths.
package wide_word_assembler_pkg;

    localparam int DEFAULT_WIDE_WIDTH   = 65;
    localparam int DEFAULT_NARROW_WIDTH = 16;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Number of narrow beats that make up one wide word.
    function automatic int beats_of(input int wide_width, input int narrow_width);
        return ceil_div(wide_width, narrow_width);
    endfunction

    // Useful bits carried by the final beat of a word.
    function automatic int last_bits_of(input int wide_width, input int narrow_width);
        return wide_width - (beats_of(wide_width, narrow_width) - 1) * narrow_width;
    endfunction

    // Width of the beat index counter, wide enough to hold 0..BEATS.
    function automatic int idx_width_of(input int beats);
        return (beats < 1) ? 1 : $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/wide_word_assembler_if.sv
// Narrow beat input, wide word output and debug index of the gearbox, bundled
// so the block and its bench share one signal definition.
interface wide_word_assembler_if
    import wide_word_assembler_pkg::*;
#(
    parameter int WIDE_WIDTH   = DEFAULT_WIDE_WIDTH,
    parameter int NARROW_WIDTH = DEFAULT_NARROW_WIDTH
);
    localparam int BEATS = beats_of(WIDE_WIDTH, NARROW_WIDTH);
    localparam int IDX_W = idx_width_of(BEATS);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both 1. A producer keeps data stable while valid is high and ready is low;
    // ready may depend combinationally on the far side only via out_ready->in_ready.
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic [NARROW_WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDE_WIDTH-1:0]   out_data;
    logic [IDX_W-1:0]        beat_idx;

    modport slave (
        input  clear,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output beat_idx
    );

    modport master (
        output clear,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  beat_idx
    );

endinterface

// File: rtl/wide_word_assembler.sv
// Deserialising gearbox: packs NARROW_WIDTH beats LSB-first into WIDE_WIDTH words,
// with a one-word output register so the next word assembles while this one drains.
module wide_word_assembler
    import wide_word_assembler_pkg::*;
#(
    parameter int WIDE_WIDTH   = DEFAULT_WIDE_WIDTH,
    parameter int NARROW_WIDTH = DEFAULT_NARROW_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wide_word_assembler_if.slave  bus_if
);

    localparam int BEATS     = beats_of(WIDE_WIDTH, NARROW_WIDTH);
    localparam int LAST_BITS = last_bits_of(WIDE_WIDTH, NARROW_WIDTH);
    localparam int IDX_W     = idx_width_of(BEATS);

    logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDE_WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDE_WIDTH-1:0] final_word;

    logic is_final;
    logic in_ready;
    logic accept;
    logic drain;

    assign is_final = (beat_idx_q == IDX_W'(BEATS - 1));
    assign drain    = out_valid_q && bus_if.out_ready;

    // Only the final beat needs space in the output register; earlier beats
    // always fit in the accumulator.
    assign in_ready = !bus_if.clear && (!is_final || !out_valid_q || bus_if.out_ready);
    assign accept   = bus_if.in_valid && in_ready;

    generate
        if (BEATS > 1) begin : g_multi
            localparam int ACC_W = (BEATS - 1) * NARROW_WIDTH;

            logic [ACC_W-1:0] acc_q, acc_d;

            always_comb begin
                acc_d = acc_q;
                if (bus_if.clear) begin
                    acc_d = '0;
                end else if (accept && !is_final) begin
                    for (int k = 0; k < BEATS - 1; k++) begin
                        if (beat_idx_q == IDX_W'(k)) begin
                            acc_d[k*NARROW_WIDTH +: NARROW_WIDTH] = bus_if.in_data;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            // Upper bits of the final beat beyond LAST_BITS are dropped here.
            assign final_word = {bus_if.in_data[LAST_BITS-1:0], acc_q};
        end else begin : g_single
            assign final_word = bus_if.in_data;
        end
    endgenerate

    always_comb begin
        beat_idx_d  = beat_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (drain) begin
            out_valid_d = 1'b0;
        end

        // A final-beat load in the same cycle as a drain overrides the clear
        // of out_valid above, so back-to-back words leave no bubble.
        if (bus_if.clear) begin
            beat_idx_d = '0;
        end else if (accept) begin
            if (is_final) begin
                out_valid_d = 1'b1;
                out_data_d  = final_word;
                beat_idx_d  = '0;
            end else begin
                beat_idx_d = beat_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            beat_idx_q  <= beat_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus_if.in_ready  = in_ready;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;
    assign bus_if.beat_idx  = beat_idx_q;

endmodule
